// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: round-robin four-approach green-phase scheduler with min/max green, yellow and all-red timing.
// The optional pedestrian WALK phase is built only when TLC_PED_EN is defined.
module tlc_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
`ifdef TLC_PED_EN
    ,
    parameter int WALK_T    = 5
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
`ifdef TLC_PED_EN
    input  logic       ped_req,
`endif
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [1:0] owner,
    output logic [3:0] pending
`ifdef TLC_PED_EN
    ,
    output logic       walk
`endif
);
    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALLRED
`ifdef TLC_PED_EN
        ,
        S_WALK
`endif
    } state_t;

    localparam logic [4:0] G_MIN = 5'(GREEN_MIN);
    localparam logic [4:0] G_MAX = 5'(GREEN_MAX);
    localparam logic [4:0] Y_T   = 5'(YELLOW_T);
    localparam logic [4:0] A_T   = 5'(ALLRED_T);
`ifdef TLC_PED_EN
    localparam logic [4:0] W_T   = 5'(WALK_T);
    logic ped_pend, ped_merged, ped_next;
`endif

    state_t     state, state_next;
    logic [3:0] timer, timer_next;
    logic [1:0] owner_next, arb, o1, o2, o3;
    logic [3:0] owner_bit, merged, pend_next;
    logic [4:0] t1;
    logic       others;

    // Request latching, round-robin arbitration and phase sequencing
    always_comb begin
        owner_bit  = 4'b0001 << owner;
        merged     = pending | (state == S_GREEN ? req & ~owner_bit : req);
        others     = |(merged & ~owner_bit);
`ifdef TLC_PED_EN
        ped_merged = ped_pend | ped_req;
        ped_next   = ped_merged;
        others     = others | ped_merged;
`endif
        t1         = {1'b0, timer} + 5'd1;
        o1         = owner + 2'd1;
        o2         = owner + 2'd2;
        o3         = owner + 2'd3;
        arb        = merged[o1] ? o1 : merged[o2] ? o2 : merged[o3] ? o3 : owner;
        state_next = state;
        timer_next = timer;
        owner_next = owner;
        pend_next  = merged;
        if (tick) begin
            case (state)
                S_GREEN: begin
                    if (t1 >= G_MIN && others) begin
                        state_next = S_YELLOW;
                        timer_next = '0;
                    end else begin
                        timer_next = t1 >= G_MAX ? 4'(G_MAX - 5'd1) : t1[3:0];
                    end
                end
                S_YELLOW: begin
                    state_next = t1 >= Y_T ? S_ALLRED : S_YELLOW;
                    timer_next = t1 >= Y_T ? 4'd0 : t1[3:0];
                end
                S_ALLRED: begin
                    timer_next = t1 >= A_T ? 4'd0 : t1[3:0];
                    if (t1 >= A_T) begin
`ifdef TLC_PED_EN
                        if (ped_merged) begin
                            state_next = S_WALK;
                            ped_next   = 1'b0;
                        end else begin
                            state_next = S_GREEN;
                            owner_next = arb;
                            pend_next  = merged & ~(4'b0001 << arb);
                        end
`else
                        state_next = S_GREEN;
                        owner_next = arb;
                        pend_next  = merged & ~(4'b0001 << arb);
`endif
                    end
                end
`ifdef TLC_PED_EN
                S_WALK: begin
                    state_next = t1 >= W_T ? S_ALLRED : S_WALK;
                    timer_next = t1 >= W_T ? 4'd0 : t1[3:0];
                end
`endif
                default: begin
                    state_next = S_GREEN;
                    timer_next = '0;
                end
            endcase
        end
    end

    // State, timer, latched requests and registered lamp drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_GREEN;
            timer    <= '0;
            owner    <= '0;
            pending  <= '0;
            green    <= 4'b0001;
            yellow   <= '0;
`ifdef TLC_PED_EN
            ped_pend <= 1'b0;
            walk     <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            owner    <= owner_next;
            pending  <= pend_next;
            green    <= state_next == S_GREEN ? 4'b0001 << owner_next : 4'b0000;
            yellow   <= state_next == S_YELLOW ? 4'b0001 << owner_next : 4'b0000;
`ifdef TLC_PED_EN
            ped_pend <= ped_next;
            walk     <= state_next == S_WALK;
`endif
        end
    end
endmodule
